snap_saver: RTL

SNAP_SAVER -- requirements
Module: snap_saver

---
 rtl/snap_saver.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/snap_saver.sv
// snap_saver: streams a .z80 v1 snapshot (header, RLE 48K image, end marker) from the CPU state and RAM
// clk_sys/reset: clock and sync reset; start/REG/border: request and latched CPU state
// mem_*: one-outstanding-read RAM port; out_*: valid/ready byte stream; busy/done: save status
module snap_saver (
  input  logic         clk_sys,
  input  logic         reset,
  input  logic         start,
  input  logic [211:0] REG,
  input  logic [2:0]   border,
  output logic [15:0]  mem_addr,
  output logic         mem_rd,
  input  logic [7:0]   mem_din,
  input  logic         mem_ready,
  output logic [7:0]   out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy,
  output logic         done
);
  typedef enum logic [2:0] {IDLE, HDR, FETCH, EMIT, TAIL, FIN} state_t;
  state_t state, nxt;
  logic [211:0] r;
  logic [2:0] brd;
  logic [4:0] idx;
  logic [7:0] v, len, k, seed, n;
  logic sv, fin_mem, xfer, got, last, same, close, enc, run_end, forced;
  logic [7:0] h [0:31];
  always_comb begin
    xfer = out_valid && out_ready;
    got = state == FETCH && mem_rd && mem_ready;
    last = mem_addr == 16'hFFFF;
    same = len != 8'd0 && mem_din == v;
    // a run closes on end of memory, on reaching 255, or on a differing byte
    close = got && (last || (same ? len == 8'd254 : len != 8'd0));
    enc = len >= 8'd5 || (v == 8'hED && len >= 8'd2);
    n = enc ? 8'd4 : len;
    run_end = state == EMIT && xfer && k == n - 8'd1;
    // a lone literal ED forces the following byte out as a one-byte literal
    forced = v == 8'hED && len == 8'd1;
  end
  always_comb begin
    h = '{default: 8'h00};
    h[0] = r[7:0];
    h[1] = r[15:8];
    h[2] = r[87:80];
    h[3] = r[95:88];
    h[4] = r[119:112];
    h[5] = r[127:120];
    h[6] = r[71:64];
    h[7] = r[79:72];
    h[8] = r[55:48];
    h[9] = r[63:56];
    h[10] = r[39:32];
    h[11] = {1'b0, r[46:40]};
    h[12] = {2'b00, 1'b1, 1'b0, brd, r[47]};
    h[13] = r[103:96];
    h[14] = r[111:104];
    h[15] = r[151:144];
    h[16] = r[159:152];
    h[17] = r[167:160];
    h[18] = r[175:168];
    h[19] = r[183:176];
    h[20] = r[191:184];
    h[21] = r[23:16];
    h[22] = r[31:24];
    h[23] = r[199:192];
    h[24] = r[207:200];
    h[25] = r[135:128];
    h[26] = r[143:136];
    h[27] = {7'b0, r[211]};
    h[28] = {7'b0, r[210]};
    h[29] = {6'b0, r[209:208]};
  end
  always_ff @(posedge clk_sys) state <= reset ? IDLE : nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE: nxt = start ? HDR : IDLE;
      HDR: nxt = xfer && idx == 5'd29 ? FETCH : HDR;
      FETCH: nxt = close ? EMIT : FETCH;
      EMIT: nxt = !run_end ? EMIT : sv ? (forced || fin_mem ? EMIT : FETCH) : fin_mem ? TAIL : FETCH;
      TAIL: nxt = xfer && idx == 5'd3 ? FIN : TAIL;
      default: nxt = IDLE;
    endcase
  end
  always_comb begin
    out_valid = state == HDR || state == EMIT || state == TAIL;
    out_data = state == HDR ? h[idx] :
               state == EMIT ? (enc && k < 8'd2 ? 8'hED : enc && k == 8'd2 ? len : v) :
               state == TAIL ? (idx == 5'd1 || idx == 5'd2 ? 8'hED : 8'h00) : 8'h00;
    busy = state != IDLE;
    done = state == FIN;
  end
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r <= '0;
      brd <= '0;
      idx <= '0;
      v <= '0;
      len <= '0;
      k <= '0;
      seed <= '0;
      sv <= 1'b0;
      fin_mem <= 1'b0;
      mem_addr <= 16'h4000;
      mem_rd <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        r <= REG;
        brd <= border;
        idx <= '0;
        len <= '0;
        k <= '0;
        sv <= 1'b0;
        fin_mem <= 1'b0;
        mem_addr <= 16'h4000;
      end
      if ((state == HDR || state == TAIL) && xfer) idx <= nxt != state ? 5'd0 : idx + 5'd1;
      // read held until acknowledged, then low for one cycle before the next
      mem_rd <= state == FETCH && (!mem_rd || !mem_ready);
      if (got) begin
        mem_addr <= last ? mem_addr : mem_addr + 16'd1;
        fin_mem <= last;
        if (!same && len != 8'd0) begin
          seed <= mem_din;
          sv <= 1'b1;
        end else begin
          v <= mem_din;
          len <= len + 8'd1;
        end
      end
      if (state == EMIT && xfer) k <= run_end ? 8'd0 : k + 8'd1;
      if (run_end) begin
        len <= sv ? 8'd1 : 8'd0;
        v <= sv ? seed : v;
        sv <= 1'b0;
      end
    end
  end
endmodule
